multicycle_controller: RTL and testbench

//  Control FSM for the multicycle ARM-subset datapath (regfile, ALU, extend, shared memory).

---
 rtl/multicycle_controller.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Module: multicycle_controller
// Control FSM for the multicycle ARM-subset datapath. Sequences the
// FETCH/DECODE/EXECUTE/MEM/WB steps, drives every datapath select, owns the
// NZCV flag register and gates architectural writes with the condition field.
// Optional feature macro: CTRL_BL_EN (branch-with-link through a BRLINK state).
// All FSM outputs are registered: the output values for the state being
// entered are computed alongside the next state and loaded on the same edge.
// Write enables are additionally masked by reset so nothing is written while
// reset is held.

module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic        LinkSel
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_BRLINK = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t      state;
    state_t      state_n;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        rd_is_pc;

    logic [3:0]  flags;
    logic        cond_ex;
    logic        cond_ok;
    logic        cond_ok_n;

    logic [1:0]  dec_alu_control;
    logic        dec_arith;
    logic        dec_known;
    logic        dec_cmp;
    logic        no_write;
    logic        flag_we;

    logic        pc_write_q;
    logic        adr_src_q;
    logic        mem_write_q;
    logic        ir_write_q;
    logic        reg_write_q;
    logic        alu_src_a_q;
    logic [1:0]  alu_src_b_q;
    logic [1:0]  alu_control_q;
    logic [1:0]  result_src_q;

    logic        pc_write_n;
    logic        adr_src_n;
    logic        mem_write_n;
    logic        ir_write_n;
    logic        reg_write_n;
    logic        alu_src_a_n;
    logic [1:0]  alu_src_b_n;
    logic [1:0]  alu_control_n;
    logic [1:0]  result_src_n;

`ifdef CTRL_BL_EN
    logic        link_sel_q;
    logic        link_sel_n;
`endif

    // Immediate, register fields and address bits this controller never looks at
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign rd       = Instr[15:12];
    assign rd_is_pc = (rd == 4'd15);

    // Register-read selects and extend mode follow the IR directly in every state
    assign RegSrc[0] = (op == 2'b10);
    assign RegSrc[1] = (op == 2'b01) && !funct[0];
    assign ImmSrc    = op;

    // Condition check against the architectural flags {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = !flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = !flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = !flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = !flags[0];
            4'b1000: cond_ex = flags[1] && !flags[2];
            4'b1001: cond_ex = !flags[1] || flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // ALU function decode from Funct[4:1]; unknown codes fall back to ADD without flags
    always_comb begin
        dec_alu_control = ALU_ADD;
        dec_arith       = 1'b0;
        dec_known       = 1'b1;
        dec_cmp         = 1'b0;
        case (funct[4:1])
            4'b0100: begin dec_alu_control = ALU_ADD; dec_arith = 1'b1; end
            4'b0010: begin dec_alu_control = ALU_SUB; dec_arith = 1'b1; end
            4'b0000: dec_alu_control = ALU_AND;
            4'b1100: dec_alu_control = ALU_ORR;
            4'b1010: begin dec_alu_control = ALU_SUB; dec_arith = 1'b1; dec_cmp = 1'b1; end
            default: begin dec_alu_control = ALU_ADD; dec_known = 1'b0; end
        endcase
    end

    // A compare only sets flags, so its writeback is suppressed
    assign no_write = (op == 2'b00) && dec_cmp;

    // Flags update at the end of an execute step when S is set (CMP always sets)
    assign flag_we = ((state == S_EXECR) || (state == S_EXECI)) && cond_ok &&
                     dec_known && (funct[0] || dec_cmp);

    // Next-state selection
    always_comb begin
        state_n = S_FETCH;
        case (state)
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_n = S_MEMADR;
                    2'b00:   state_n = funct[5] ? S_EXECI : S_EXECR;
`ifdef CTRL_BL_EN
                    2'b10:   state_n = funct[4] ? S_BRLINK : S_BRANCH;
`else
                    2'b10:   state_n = S_BRANCH;
`endif
                    default: state_n = S_FETCH;
                endcase
            end
            S_MEMADR: state_n = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_n = S_MEMWB;
            S_MEMWB:  state_n = S_FETCH;
            S_MEMWR:  state_n = S_FETCH;
            S_EXECR:  state_n = S_ALUWB;
            S_EXECI:  state_n = S_ALUWB;
            S_ALUWB:  state_n = S_FETCH;
            S_BRANCH: state_n = S_FETCH;
            S_BRLINK: state_n = S_BRANCH;
            default:  state_n = S_FETCH;
        endcase
    end

    // Output values for the state being entered, using the condition result it will see
    always_comb begin
        cond_ok_n     = (state == S_DECODE) ? cond_ex : cond_ok;
        pc_write_n    = 1'b0;
        adr_src_n     = 1'b0;
        mem_write_n   = 1'b0;
        ir_write_n    = 1'b0;
        reg_write_n   = 1'b0;
        alu_src_a_n   = 1'b0;
        alu_src_b_n   = 2'b00;
        alu_control_n = ALU_ADD;
        result_src_n  = 2'b00;
`ifdef CTRL_BL_EN
        link_sel_n    = 1'b0;
`endif
        case (state_n)
            S_FETCH: begin
                ir_write_n   = 1'b1;
                pc_write_n   = 1'b1;
                alu_src_a_n  = 1'b1;
                alu_src_b_n  = 2'b10;
                result_src_n = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_n  = 1'b1;
                alu_src_b_n  = 2'b10;
                result_src_n = 2'b10;
            end
            S_MEMADR: alu_src_b_n = 2'b01;
            S_MEMRD:  adr_src_n = 1'b1;
            S_MEMWB: begin
                result_src_n = 2'b01;
                reg_write_n  = cond_ok_n;
                pc_write_n   = cond_ok_n && rd_is_pc;
            end
            S_MEMWR: begin
                adr_src_n   = 1'b1;
                mem_write_n = cond_ok_n;
            end
            S_EXECR: begin
                alu_src_b_n   = 2'b00;
                alu_control_n = dec_alu_control;
            end
            S_EXECI: begin
                alu_src_b_n   = 2'b01;
                alu_control_n = dec_alu_control;
            end
            S_ALUWB: begin
                result_src_n = 2'b00;
                reg_write_n  = cond_ok_n && !no_write;
                pc_write_n   = cond_ok_n && rd_is_pc;
            end
            S_BRANCH: begin
                alu_src_b_n  = 2'b01;
                result_src_n = 2'b10;
                pc_write_n   = cond_ok_n;
            end
`ifdef CTRL_BL_EN
            S_BRLINK: begin
                alu_src_a_n  = 1'b1;
                alu_src_b_n  = 2'b10;
                result_src_n = 2'b10;
                link_sel_n   = 1'b1;
                reg_write_n  = cond_ok_n;
            end
`endif
            default: begin
                pc_write_n = 1'b0;
            end
        endcase
    end

    // FSM state, condition latch, flag register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            flags         <= 4'b0000;
            cond_ok       <= 1'b0;
            pc_write_q    <= 1'b1;
            adr_src_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            ir_write_q    <= 1'b1;
            reg_write_q   <= 1'b0;
            alu_src_a_q   <= 1'b1;
            alu_src_b_q   <= 2'b10;
            alu_control_q <= ALU_ADD;
            result_src_q  <= 2'b10;
`ifdef CTRL_BL_EN
            link_sel_q    <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cond_ok       <= cond_ok_n;
            pc_write_q    <= pc_write_n;
            adr_src_q     <= adr_src_n;
            mem_write_q   <= mem_write_n;
            ir_write_q    <= ir_write_n;
            reg_write_q   <= reg_write_n;
            alu_src_a_q   <= alu_src_a_n;
            alu_src_b_q   <= alu_src_b_n;
            alu_control_q <= alu_control_n;
            result_src_q  <= result_src_n;
`ifdef CTRL_BL_EN
            link_sel_q    <= link_sel_n;
`endif
            if (flag_we) begin
                flags[3:2] <= ALUFlags[3:2];
                if (dec_arith) begin
                    flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    assign PCWrite    = pc_write_q  && !reset;
    assign MemWrite   = mem_write_q && !reset;
    assign IRWrite    = ir_write_q  && !reset;
    assign RegWrite   = reg_write_q && !reset;
    assign AdrSrc     = adr_src_q;
    assign ALUSrcA    = alu_src_a_q;
    assign ALUSrcB    = alu_src_b_q;
    assign ALUControl = alu_control_q;
    assign ResultSrc  = result_src_q;
`ifdef CTRL_BL_EN
    assign LinkSel    = link_sel_q;
`else
    assign LinkSel    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench: tb_multicycle_controller
// Directed instruction sequences through multicycle_controller; every cycle the
// full output vector is compared with a hand-derived expectation.
// Build with CTRL_BL_EN defined to exercise the BRLINK path.

module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  RegSrc, ImmSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB, ALUControl, ResultSrc;
    logic        LinkSel;

    int checks = 0;
    int errors = 0;

    // Output vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,RegSrc,ImmSrc,ALUSrcA,ALUSrcB,ALUControl,ResultSrc,LinkSel}
    logic [16:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, LinkSel};

    localparam logic [16:0] ALL   = 17'h1FFFF;
    localparam logic [16:0] WE    = 17'h17000;
    localparam logic [16:0] NOFWR = 17'h0DFFF;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .LinkSel    (LinkSel)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] imm, input logic a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] r, input logic l);
        return {pcw, adr, mw, irw, rw, rs, imm, a, b, c, r, l};
    endfunction

    function automatic logic [16:0] fv(input logic [1:0] rs, input logic [1:0] imm);
        return ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rs, imm, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0);
    endfunction

    function automatic logic [16:0] dv(input logic [1:0] rs, input logic [1:0] imm);
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs, imm, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0);
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] fl);
        Instr    = ins;
        ALUFlags = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [16:0] exp, input logic [16:0] mask);
        checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            errors++;
            $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs & mask, exp & mask);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic [16:0] exp);
        tick();
        checkOutput(tag, exp, ALL);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(32'h0000_0000, 4'b0000);
        tick();
        tick();
        checkOutput("reset_we", 17'h0, WE);
        reset = 1'b0;

        // ADD R1,R2,R3
        applyStimulus(32'hE082_1003, 4'b0000);
        checkOutput("add_fetch0", fv(2'b00, 2'b00), 17'h05000);
        stepCheck("add_decode", dv(2'b00, 2'b00));
        stepCheck("add_execr",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("add_aluwb",  ov(0,0,0,0,1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("add_fetch",  fv(2'b00, 2'b00));

        // SUB R1,R2,R3
        applyStimulus(32'hE042_1003, 4'b0000);
        stepCheck("sub_decode", dv(2'b00, 2'b00));
        stepCheck("sub_execr",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0));
        stepCheck("sub_aluwb",  ov(0,0,0,0,1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("sub_fetch",  fv(2'b00, 2'b00));

        // ADD PC,R2,R3 also writes the PC
        applyStimulus(32'hE082_F003, 4'b0000);
        stepCheck("addpc_decode", dv(2'b00, 2'b00));
        stepCheck("addpc_execr",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("addpc_aluwb",  ov(1,0,0,0,1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("addpc_fetch",  fv(2'b00, 2'b00));

        // LDR R1,[R2,#4]
        applyStimulus(32'hE592_1004, 4'b0000);
        stepCheck("ldr_decode", dv(2'b00, 2'b01));
        stepCheck("ldr_memadr", ov(0,0,0,0,0, 2'b00, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0));
        stepCheck("ldr_memrd",  ov(0,1,0,0,0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("ldr_memwb",  ov(0,0,0,0,1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0));
        stepCheck("ldr_fetch",  fv(2'b00, 2'b01));

        // STR R1,[R2,#4]
        applyStimulus(32'hE582_1004, 4'b0000);
        stepCheck("str_decode", dv(2'b10, 2'b01));
        stepCheck("str_memadr", ov(0,0,0,0,0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0));
        stepCheck("str_memwr",  ov(0,1,1,0,0, 2'b10, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("str_fetch",  fv(2'b10, 2'b01));

        // CMP R1,#0 with Z from the ALU, then BEQ taken
        applyStimulus(32'hE351_0000, 4'b0100);
        stepCheck("cmp1_decode", dv(2'b00, 2'b00));
        stepCheck("cmp1_execi",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0));
        stepCheck("cmp1_aluwb",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("cmp1_fetch",  fv(2'b00, 2'b00));
        applyStimulus(32'h0A00_0002, 4'b0000);
        stepCheck("beq1_decode", dv(2'b01, 2'b10));
        stepCheck("beq1_branch", ov(1,0,0,0,0, 2'b01, 2'b10, 0, 2'b01, 2'b00, 2'b10, 0));
        stepCheck("beq1_fetch",  fv(2'b01, 2'b10));

        // CMP clearing Z, then BEQ not taken
        applyStimulus(32'hE351_0000, 4'b0000);
        stepCheck("cmp2_decode", dv(2'b00, 2'b00));
        stepCheck("cmp2_execi",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0));
        stepCheck("cmp2_aluwb",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("cmp2_fetch",  fv(2'b00, 2'b00));
        applyStimulus(32'h0A00_0002, 4'b0000);
        stepCheck("beq2_decode", dv(2'b01, 2'b10));
        stepCheck("beq2_branch", ov(0,0,0,0,0, 2'b01, 2'b10, 0, 2'b01, 2'b00, 2'b10, 0));
        stepCheck("beq2_fetch",  fv(2'b01, 2'b10));

        // ORRS sets N,Z only; C and V stay clear
        applyStimulus(32'hE391_1001, 4'b1111);
        stepCheck("orrs_decode", dv(2'b00, 2'b00));
        stepCheck("orrs_execi",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 2'b11, 2'b00, 0));
        stepCheck("orrs_aluwb",  ov(0,0,0,0,1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("orrs_fetch",  fv(2'b00, 2'b00));
        applyStimulus(32'h2A00_0002, 4'b0000);
        stepCheck("bcs_decode", dv(2'b01, 2'b10));
        stepCheck("bcs_branch", ov(0,0,0,0,0, 2'b01, 2'b10, 0, 2'b01, 2'b00, 2'b10, 0));
        stepCheck("bcs_fetch",  fv(2'b01, 2'b10));
        applyStimulus(32'h4A00_0002, 4'b0000);
        stepCheck("bmi_decode", dv(2'b01, 2'b10));
        stepCheck("bmi_branch", ov(1,0,0,0,0, 2'b01, 2'b10, 0, 2'b01, 2'b00, 2'b10, 0));
        stepCheck("bmi_fetch",  fv(2'b01, 2'b10));

        // ADDNE with Z set walks every state but writes nothing
        applyStimulus(32'h1082_1003, 4'b0000);
        stepCheck("addne_decode", dv(2'b00, 2'b00));
        stepCheck("addne_execr",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("addne_aluwb",  ov(0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("addne_fetch",  fv(2'b00, 2'b00));

        // Undefined opcode behaves as a two-cycle NOP
        applyStimulus(32'hEC00_0000, 4'b0000);
        stepCheck("undef_decode", dv(2'b00, 2'b11));
        stepCheck("undef_fetch",  fv(2'b00, 2'b11));

        // BL: link step only when the feature is built in
        applyStimulus(32'hEB00_0002, 4'b0000);
        stepCheck("bl_decode", dv(2'b01, 2'b10));
`ifdef CTRL_BL_EN
        stepCheck("bl_brlink", ov(0,0,0,0,1, 2'b01, 2'b10, 1, 2'b10, 2'b00, 2'b10, 1));
`endif
        stepCheck("bl_branch", ov(1,0,0,0,0, 2'b01, 2'b10, 0, 2'b01, 2'b00, 2'b10, 0));
        stepCheck("bl_fetch",  fv(2'b01, 2'b10));

        // Reset during MEMRD aborts the load
        applyStimulus(32'hE592_1004, 4'b0000);
        stepCheck("rldr_decode", dv(2'b00, 2'b01));
        stepCheck("rldr_memadr", ov(0,0,0,0,0, 2'b00, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0));
        stepCheck("rldr_memrd",  ov(0,1,0,0,0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0));
        reset = 1'b1;
        #1;
        checkOutput("rldr_rst_we", 17'h0, WE);
        tick();
        checkOutput("rldr_rst2_we", 17'h0, WE);
        reset = 1'b0;
        #1;
        checkOutput("rldr_fetch", fv(2'b00, 2'b01), NOFWR);
        stepCheck("rldr2_decode", dv(2'b00, 2'b01));
        stepCheck("rldr2_memadr", ov(0,0,0,0,0, 2'b00, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0));
        stepCheck("rldr2_memrd",  ov(0,1,0,0,0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0));
        stepCheck("rldr2_memwb",  ov(0,0,0,0,1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b01, 0));
        stepCheck("rldr2_fetch",  fv(2'b00, 2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
